// File: rtl/rms_pkg.sv
// rms_pkg: shared types and constants for the streaming RMS engine.
//   state_t    - controller states (ACCUM, DIV, SQRT, DONE)
//   calc_accw  - accumulator / dividend width for a given sample width and window
//   RST_*      - register values restored by the asynchronous reset
package rms_pkg;

   typedef enum logic [1:0] {ACCUM, DIV, SQRT, DONE} state_t;

   localparam state_t RST_STATE     = ACCUM;
   localparam logic   RST_OUT_VALID = 1'b0;
   localparam logic   RST_BUSY      = 1'b0;

   // Sum of N squares of WIDTH-bit samples needs 2*WIDTH + clog2(N) bits.
   function automatic int calc_accw(input int width, input int n);
      return 2 * width + $clog2(n);
   endfunction

endpackage

// File: rtl/rms_stream_if.sv
// rms_stream_if: sample input and result output handshakes of rms_stream.
//   in_valid/in_data/in_ready - sample stream (producer -> engine)
//   flush                     - discard the partial window
//   out_valid/out_rms/out_ready - result stream (engine -> consumer)
//   busy                      - engine is dividing, rooting or holding a result
// master: the side that drives samples and consumes results; slave: the engine.
interface rms_stream_if #(parameter int WIDTH = 4);
   logic             in_valid;
   logic [WIDTH-1:0] in_data;
   logic             in_ready;
   logic             flush;
   logic             out_valid;
   logic [WIDTH-1:0] out_rms;
   logic             out_ready;
   logic             busy;

   modport master (output in_valid, in_data, flush, out_ready,
                   input  in_ready, out_valid, out_rms, busy);
   modport slave  (input  in_valid, in_data, flush, out_ready,
                   output in_ready, out_valid, out_rms, busy);
endinterface

// File: rtl/isqrt_iter.sv
// isqrt_iter: digit-by-digit integer square root, one root bit per cycle, MSB first.
//   clk, rst_n - clock, asynchronous active-low reset
//   start      - one-cycle pulse; radicand is sampled and the first bit computed on this edge
//   radicand   - 2*WIDTH-bit unsigned operand
//   done       - one-cycle pulse after the WIDTH-th bit has been produced
//   root       - floor(sqrt(radicand)), valid from done until the next start
module isqrt_iter #(
   parameter int WIDTH = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic [2*WIDTH-1:0] radicand,
   output logic               done,
   output logic [WIDTH-1:0]   root
);
   localparam int IW = $clog2(WIDTH);

   logic [2*WIDTH-1:0] x_q, x_src, x_nxt;
   logic [WIDTH+1:0]   rem_q, rem_src, rem_nxt;
   logic [WIDTH-1:0]   root_q, root_src, root_nxt;
   logic [WIDTH+3:0]   cand, trial;
   logic               take, active;
   logic [IW-1:0]      it;

   // The start edge already performs iteration 1 from the fresh operand, so the
   // whole root takes exactly WIDTH edges.
   always_comb begin
      // NOTE: every signal gets a value on entry, so no path can infer a latch.
      rem_src  = start ? '0 : rem_q;
      root_src = start ? '0 : root_q;
      x_src    = start ? radicand : x_q;
      cand     = {rem_src, x_src[2*WIDTH-1 -: 2]};
      trial    = {2'b00, root_src, 2'b01};
      take     = (cand >= trial);
      rem_nxt  = take ? (WIDTH+2)'(cand - trial) : (WIDTH+2)'(cand);
      root_nxt = WIDTH'({root_src, take});
      x_nxt    = x_src << 2;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         x_q    <= '0;
         rem_q  <= '0;
         root_q <= '0;
         active <= 1'b0;
         it     <= '0;
         done   <= 1'b0;
      end else begin
         done <= 1'b0;
         if (start || active) begin
            x_q    <= x_nxt;
            rem_q  <= rem_nxt;
            root_q <= root_nxt;
         end
         if (start) begin
            active <= 1'b1;
            it     <= IW'(1);
         end else if (active) begin
            it <= it + IW'(1);
            if (it == IW'(WIDTH - 1)) begin
               active <= 1'b0;
               done   <= 1'b1;
            end
         end
      end
   end

   assign root = root_q;

endmodule

// File: rtl/rms_stream.sv
// rms_stream: windowed RMS engine, out_rms = floor(sqrt(floor(sum(x^2) / N))).
//   clk, rst_n - clock, asynchronous active-low reset
//   bus        - rms_stream_if slave: sample handshake in, result handshake out,
//                flush (drops the partial window, ignored while computing), busy
// Squares are accumulated in ACCUM; a restoring divider by the constant N runs
// ACCW cycles in DIV; isqrt_iter runs WIDTH cycles in SQRT; DONE holds the result.
module rms_stream
   import rms_pkg::*;
#(
   parameter int WIDTH = 4,
   parameter int N     = 5
) (
   input  logic     clk,
   input  logic     rst_n,
   rms_stream_if.slave bus
);
   localparam int ACCW = calc_accw(WIDTH, N);
   localparam int CW   = $clog2(N + 1);
   localparam int DCW  = $clog2(ACCW);

   state_t           state, state_nxt;
   logic [ACCW-1:0]  acc, quo, rem, rem_nxt, sq;
   logic [ACCW:0]    rem_sh;
   logic [CW-1:0]    cnt;
   logic [DCW-1:0]   dcnt;
   logic             accept, last_sample, div_last, q_bit;
   logic             sq_start, sq_done;
   logic [WIDTH-1:0] root, out_rms_q;
   logic             out_valid_q, busy_q;

   assign bus.in_ready = (state == ACCUM);
   assign accept       = bus.in_valid && (state == ACCUM);
   assign sq           = ACCW'(bus.in_data) * ACCW'(bus.in_data);
   assign last_sample  = (cnt == CW'(N - 1));
   assign div_last     = (dcnt == DCW'(ACCW - 1));

   // One restoring step: the remainder stays below N, so rem_sh < 2N.
   assign rem_sh  = {rem, quo[ACCW-1]};
   assign q_bit   = (rem_sh >= (ACCW+1)'(N));
   assign rem_nxt = q_bit ? ACCW'(rem_sh - (ACCW+1)'(N)) : ACCW'(rem_sh);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= RST_STATE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         ACCUM: if (accept && !bus.flush && last_sample) state_nxt = DIV;
         DIV:   if (div_last)                            state_nxt = SQRT;
         SQRT:  if (sq_done)                             state_nxt = DONE;
         DONE:  if (bus.out_ready)                       state_nxt = ACCUM;
         default:                                        state_nxt = RST_STATE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc         <= '0;
         cnt         <= '0;
         quo         <= '0;
         rem         <= '0;
         dcnt        <= '0;
         sq_start    <= 1'b0;
         out_valid_q <= RST_OUT_VALID;
         out_rms_q   <= '0;
         busy_q      <= RST_BUSY;
      end else begin
         // NOTE: non-blocking assignments keep every register update here reading
         // the pre-edge values, independent of statement order.
         sq_start    <= 1'b0;
         busy_q      <= (state_nxt != ACCUM);
         out_valid_q <= (state_nxt == DONE);
         unique case (state)
            ACCUM: begin
               // flush outranks a sample offered in the same cycle
               if (bus.flush) begin
                  acc <= '0;
                  cnt <= '0;
               end else if (accept) begin
                  if (last_sample) begin
                     quo  <= acc + sq;
                     rem  <= '0;
                     dcnt <= '0;
                     cnt  <= '0;
                  end else begin
                     acc <= acc + sq;
                     cnt <= cnt + CW'(1);
                  end
               end
            end
            DIV: begin
               quo  <= {quo[ACCW-2:0], q_bit};
               rem  <= rem_nxt;
               dcnt <= dcnt + DCW'(1);
               // the root starts one edge later, once the last quotient bit is in
               if (div_last) sq_start <= 1'b1;
            end
            SQRT: if (sq_done) out_rms_q <= root;
            DONE: if (bus.out_ready) acc <= '0;
            default: ;
         endcase
      end
   end

   // The quotient never exceeds (2^WIDTH-1)^2, so its low 2*WIDTH bits are the mean.
   isqrt_iter #(.WIDTH(WIDTH)) u_isqrt (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (sq_start),
      .radicand (quo[2*WIDTH-1:0]),
      .done     (sq_done),
      .root     (root)
   );

   assign bus.out_valid = out_valid_q;
   assign bus.out_rms   = out_rms_q;
   assign bus.busy      = busy_q;

endmodule
